// File: rtl/cpu_ctrl_seq.sv
// Eight-phase control sequencer for the RISC CPU with retired-instruction counter.
// Optional single-step gating at phase 0 is enabled by defining CTRL_SINGLE_STEP_EN.
`timescale 1ns/1ps
module cpu_ctrl_seq #(
  parameter int unsigned CNT_W      = 16,
  parameter bit          HLT_STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcd,
  input  logic             zero,
  input  logic             resume,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             ldir,
  output logic             inc_pc,
  output logic             ldpc,
  output logic             ldac,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e           state;
  logic             halted;
  logic [CNT_W-1:0] icount_q;
  logic [2:0]       phase_nxt;
  logic             advance;
  logic             is_hlt;
  logic             is_skz;
  logic             is_sto;
  logic             is_jmp;
  logic             is_alu;

  assign is_hlt    = (opcd == OP_HLT);
  assign is_skz    = (opcd == OP_SKZ);
  assign is_sto    = (opcd == OP_STO);
  assign is_jmp    = (opcd == OP_JMP);
  assign is_alu    = (opcd == OP_ADD) || (opcd == OP_AND) ||
                     (opcd == OP_XOR) || (opcd == OP_LDA);
  assign phase_nxt = state + 3'd1;

  // Phase 0 waits for a step pulse when single-stepping is built in.
`ifdef CTRL_SINGLE_STEP_EN
  assign advance = (state != INST_ADDR) || step;
`else
  assign advance = 1'b1;
`endif

  // Phase sequencing, halt capture and instruction retirement count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INST_ADDR;
      halted   <= 1'b0;
      icount_q <= '0;
    end else if (halted) begin
      if (!HLT_STICKY && resume) begin
        halted <= 1'b0;
        state  <= OP_FETCH;
      end
    end else if (state == OP_ADDR && is_hlt) begin
      halted <= 1'b1;
    end else if (advance) begin
      state <= phase_e'(phase_nxt);
      if (state == STORE) icount_q <= icount_q + CNT_W'(1);
    end
  end

  // Strobe decode from phase, opcode, zero flag and halt state.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ldir   = 1'b0;
    inc_pc = 1'b0;
    ldpc   = 1'b0;
    ldac   = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (state)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ldir = 1'b1; end
        OP_ADDR:    begin inc_pc = 1'b1; halt = is_hlt; end
        OP_FETCH:   rd = is_alu;
        ALU_OP: begin
          rd     = is_alu;
          inc_pc = is_skz && zero;
          ldpc   = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = is_alu;
          ldac   = is_alu;
          inc_pc = is_jmp;
          ldpc   = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase  = state;
  assign icount = icount_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: sticky (CNT_W=4) and resumable (CNT_W=16) instances.
`timescale 1ns/1ps
module tb_cpu_ctrl_seq;

  typedef struct packed {
    logic       sel, rd, wr, ldir, inc_pc, ldpc, ldac, data_e, halt;
    logic [2:0] phase;
    logic [15:0] icount;
  } out_t;

  typedef struct packed {
    logic [2:0] opcd;
    logic       zero;
    logic [7:0] sel, rd, ldir, inc_pc, ldpc, ldac, wr, data_e;
  } tv_t;

  logic clk = 1'b0;
  logic rst, zero, resume, step;
  logic [2:0] opcd;
  logic sel [2], rd [2], wr [2], ldir [2], inc_pc [2], ldpc [2], ldac [2], data_e [2], halt [2];
  logic [2:0] phase [2];
  logic [3:0] icount0;
  logic [15:0] icount1;

  int n_checks = 0;
  int n_fail   = 0;
  int m_phase [2];
  bit m_halted [2];
  int m_icount [2];
  tv_t tv [8];

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.CNT_W(4), .HLT_STICKY(1'b1)) u_sticky (
    .clk(clk), .rst(rst), .opcd(opcd), .zero(zero), .resume(resume),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .sel(sel[0]), .rd(rd[0]), .wr(wr[0]), .ldir(ldir[0]), .inc_pc(inc_pc[0]),
    .ldpc(ldpc[0]), .ldac(ldac[0]), .data_e(data_e[0]), .halt(halt[0]),
    .phase(phase[0]), .icount(icount0)
  );

  cpu_ctrl_seq #(.CNT_W(16), .HLT_STICKY(1'b0)) u_resum (
    .clk(clk), .rst(rst), .opcd(opcd), .zero(zero), .resume(resume),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .sel(sel[1]), .rd(rd[1]), .wr(wr[1]), .ldir(ldir[1]), .inc_pc(inc_pc[1]),
    .ldpc(ldpc[1]), .ldac(ldac[1]), .data_e(data_e[1]), .halt(halt[1]),
    .phase(phase[1]), .icount(icount1)
  );

  function automatic out_t get_obs(int i);
    out_t o;
    o.sel = sel[i]; o.rd = rd[i]; o.wr = wr[i]; o.ldir = ldir[i];
    o.inc_pc = inc_pc[i]; o.ldpc = ldpc[i]; o.ldac = ldac[i];
    o.data_e = data_e[i]; o.halt = halt[i]; o.phase = phase[i];
    o.icount = (i == 0) ? 16'(icount0) : icount1;
    return o;
  endfunction

  // Reference: expected outputs straight from the phase/opcode rules.
  function automatic out_t model_out(int i);
    out_t o;
    int p = m_phase[i];
    bit alu = (opcd >= 3'd2) && (opcd <= 3'd5);
    o = '0;
    o.phase  = 3'(p);
    o.icount = 16'(m_icount[i]);
    if (m_halted[i]) begin
      o.halt = 1'b1;
    end else begin
      o.sel    = (p < 4);
      o.rd     = (p >= 1 && p <= 3) || (p >= 5 && alu);
      o.ldir   = (p == 2 || p == 3);
      o.inc_pc = (p == 4) || (p == 6 && opcd == 3'd1 && zero) || (p == 7 && opcd == 3'd7);
      o.ldpc   = (p >= 6 && opcd == 3'd7);
      o.ldac   = (p == 7 && alu);
      o.wr     = (p == 7 && opcd == 3'd6);
      o.data_e = (p >= 6 && opcd == 3'd6);
      o.halt   = (p == 4 && opcd == 3'd0);
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_halted[i] = 1'b0; m_icount[i] = 0;
    end
  endtask

  // Advance the reference by one clock edge using the inputs present at that edge.
  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int mask = (i == 0) ? 'hF : 'hFFFF;
      bit sticky = (i == 0);
      if (m_halted[i]) begin
        if (!sticky && resume) begin m_halted[i] = 1'b0; m_phase[i] = 5; end
      end else if (m_phase[i] == 4 && opcd == 3'd0) begin
        m_halted[i] = 1'b1;
      end else if (m_phase[i] == 0 && !step) begin
        m_phase[i] = 0;
      end else begin
        if (m_phase[i] == 7) m_icount[i] = (m_icount[i] + 1) & mask;
        m_phase[i] = (m_phase[i] + 1) % 8;
      end
    end
  endtask

  task automatic check(string name, int i);
    out_t got = get_obs(i);
    out_t exp = model_out(i);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h", name, i, got, exp);
    end
  endtask

  task automatic check_val(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: compare both instances mid-cycle, then step the model at the edge.
  task automatic tick(string name);
    @(negedge clk);
    check(name, 0);
    check(name, 1);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset", 0);
    check("reset", 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] got, exp;
    out_t o;
    rst = 1'b1; opcd = 3'd2; zero = 1'b0; resume = 1'b0; step = 1'b1;
    model_reset();
    #1;
    check_val("reset_phase", int'(phase[0]), 0);
    check_val("reset_sel", int'(sel[1]), 1);
    check_val("reset_icount", int'(icount1), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    tv[0] = '{3'd2, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00};
    tv[1] = '{3'd1, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[2] = '{3'd1, 1'b0, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[3] = '{3'd6, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h80, 8'hC0};
    tv[4] = '{3'd7, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h90, 8'hC0, 8'h00, 8'h00, 8'h00};
    tv[5] = '{3'd3, 1'b1, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00};
    tv[6] = '{3'd4, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00};
    tv[7] = '{3'd5, 1'b1, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00};

    // Table: one full instruction per record, every phase compared to constant masks.
    for (int r = 0; r < 8; r++) begin
      opcd = tv[r].opcd;
      zero = tv[r].zero;
      for (int ph = 0; ph < 8; ph++) begin
        @(negedge clk);
        exp = {tv[r].sel[ph], tv[r].rd[ph], tv[r].wr[ph], tv[r].ldir[ph], tv[r].inc_pc[ph],
               tv[r].ldpc[ph], tv[r].ldac[ph], tv[r].data_e[ph], 1'b0, 3'(ph)};
        for (int i = 0; i < 2; i++) begin
          o = get_obs(i);
          got = {o.sel, o.rd, o.wr, o.ldir, o.inc_pc, o.ldpc, o.ldac, o.data_e, o.halt, o.phase};
          n_checks++;
          if (got !== exp) begin
            n_fail++;
            $display("FAIL table rec%0d phase%0d inst%0d: got %h expected %h", r, ph, i, got, exp);
          end
        end
        @(posedge clk);
        model_update();
        #1;
      end
      check_val("table_icount", int'(icount1), r + 1);
    end

    // Reset in the middle of phase 5 of an ADD.
    opcd = 3'd2; zero = 1'b0;
    for (int k = 0; k < 5; k++) tick("pre_reset");
    check_val("pre_reset_phase", int'(phase[0]), 5);
    #2;
    apply_reset();
    check_val("post_reset_icount", int'(icount0), 0);

    // ADD retires after eight clocks.
    for (int k = 0; k < 8; k++) tick("add");
    check_val("add_icount0", int'(icount0), 1);
    check_val("add_icount1", int'(icount1), 1);

    // HLT: both halt; sticky stays, resumable leaves on a resume pulse.
    opcd = 3'd0;
    for (int k = 0; k < 4; k++) tick("hlt_enter");
    for (int k = 0; k < 21; k++) tick("hlt_hold");
    check_val("hlt_phase", int'(phase[0]), 4);
    check_val("hlt_halt", int'(halt[0]), 1);
    check_val("hlt_inc_pc", int'(inc_pc[0]), 0);
    check_val("hlt_icount", int'(icount0), 1);
    resume = 1'b1;
    tick("resume");
    resume = 1'b0;
    check_val("resume_phase1", int'(phase[1]), 5);
    check_val("resume_phase0", int'(phase[0]), 4);
    for (int k = 0; k < 3; k++) tick("hlt_retire");
    check_val("hlt_retire_icount1", int'(icount1), 2);
    check_val("hlt_retire_phase1", int'(phase[1]), 0);
    check_val("sticky_icount0", int'(icount0), 1);
    resume = 1'b1;
    opcd = 3'd2;
    for (int k = 0; k < 3; k++) tick("resume_ignored");
    resume = 1'b0;
    apply_reset();

    // Counter wrap on the 4-bit instance.
    opcd = 3'd3;
    for (int k = 0; k < 15 * 8; k++) tick("wrap");
    check_val("wrap_15", int'(icount0), 15);
    for (int k = 0; k < 8; k++) tick("wrap");
    check_val("wrap_0", int'(icount0), 0);
    check_val("wrap_16", int'(icount1), 16);

`ifdef CTRL_SINGLE_STEP_EN
    apply_reset();
    step = 1'b0;
    for (int k = 0; k < 10; k++) tick("step_wait");
    check_val("step_wait_phase", int'(phase[0]), 0);
    step = 1'b1;
    tick("step_pulse");
    step = 1'b0;
    for (int k = 1; k < 8; k++) tick("step_run");
    check_val("step_done_phase", int'(phase[1]), 0);
    for (int k = 0; k < 5; k++) tick("step_hold");
    check_val("step_hold_phase", int'(phase[1]), 0);
    check_val("step_icount", int'(icount1), 1);
    step = 1'b1;
`endif

    // Randomised traffic against the reference model.
    for (int k = 0; k < 2000; k++) begin
      zero   = 1'($urandom);
      resume = ($urandom % 8 == 0);
      if (m_phase[0] == 0 || m_phase[1] == 0)
        opcd = ($urandom % 6 == 0) ? 3'd0 : 3'(1 + $urandom % 7);
`ifdef CTRL_SINGLE_STEP_EN
      step = ($urandom % 3 != 0);
`endif
      if ($urandom % 100 == 0) begin
        rst = 1'b1;
        model_reset();
        tick("rand_reset");
        rst = 1'b0;
      end else begin
        tick("random");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Eight-phase control sequencer for the RISC CPU. It drives the instruction register load strobe, memory read/write, PC increment/load, accumulator load and data-bus enable.
- Decodes the 3-bit opcode held in the instruction register together with the accumulator zero flag.
- Sits between the instruction register/ALU/accumulator datapath and the memory and PC blocks. Also counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter
- HLT_STICKY, 1, 1 = halt holds until reset; 0 = halt released by resume pulse

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- opcd  in  3  opcode from instruction register (valid from phase 3)
- zero  in  1  accumulator-zero flag
- resume  in  1  leave halt (used only when HLT_STICKY=0)
- sel  out  1  address mux select (1 = PC, 0 = IR operand)
- rd  out  1  memory read
- wr  out  1  memory write
- ldir  out  1  instruction register load
- inc_pc  out  1  PC increment
- ldpc  out  1  PC load
- ldac  out  1  accumulator load
- data_e  out  1  accumulator drives data bus
- halt  out  1  CPU halted
- phase  out  3  current phase 0..7
- icount  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD/AND/XOR/LDA.
- State: 3-bit phase register plus halted flag. phase advances 0→7→0 on each clk when not halted.
- Outputs are combinational decode of phase, opcd, zero and halted. No output registers beyond phase, halted and icount.
- Phase decode (unlisted outputs are 0):
  - 0 INST_ADDR: sel
  - 1 INST_FETCH: sel, rd
  - 2 INST_LOAD: sel, rd, ldir
  - 3 IDLE: sel, rd, ldir
  - 4 OP_ADDR: inc_pc; halt=1 if opcd==HLT
  - 5 OP_FETCH: rd=ALUOP
  - 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ldpc=JMP; data_e=STO
  - 7 STORE: rd=ALUOP; ldac=ALUOP; inc_pc=JMP; ldpc=JMP; wr=STO; data_e=STO
- HLT: at the phase-4 edge, halted is set and phase stays 4.
  - While halted: halt=1 and all other strobes are 0, including inc_pc.
  - HLT_STICKY=1: only rst clears halted.
  - HLT_STICKY=0: resume=1 while halted clears halted and moves phase to 5. The HLT instruction then retires normally.
- icount increments by 1 on each 7→0 transition, wrapping modulo 2^CNT_W. A halted HLT does not increment until it completes phase 7.
- rst asserted at any time, including mid-instruction:
  - immediately: phase=0, halted=0, icount=0
  - outputs: sel=1, all other strobes 0, halt=0, phase=0, icount=0
- resume while not halted: ignored.
- zero is sampled only in phase 6. Changes in other phases have no effect.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN adds input step (1 bit).
- With the macro: after phase 7 the sequencer enters a wait (phase held at 0, halted=0, sel=1, other strobes 0). It advances 0→1 only on a cycle where step=1. One step pulse = one full instruction; step held high = free-running.
- Without the macro: the step port does not exist and phase 0 always advances on the next clk.
- icount increments on the 7→0 transition in both builds.

Test Plan:
- Reset: rst=1 mid-phase 5 of ADD → same cycle phase=0, sel=1, rd=ldir=wr=inc_pc=ldpc=ldac=data_e=halt=0, icount=0.
- ADD (opcd=2) full instruction:
  - rd=1 in phases 1,2,3,5,6,7
  - ldir=1 in phases 2,3
  - inc_pc=1 in phase 4 only
  - ldac=1 in phase 7 only
  - icount 0→1 after 8 clocks
- SKZ (opcd=1):
  - zero=1 → inc_pc=1 in phases 4 and 6
  - zero=0 → inc_pc=1 in phase 4 only
  - no rd in phases 5–7
- STO (opcd=6): data_e=1 in phases 6,7; wr=1 in phase 7 only; ldac=0 throughout. JMP (opcd=7): ldpc=1 in phases 6,7; inc_pc=1 in phase 7.
- HLT (opcd=0):
  - HLT_STICKY=1: phase sticks at 4, halt=1 for 20 clocks, inc_pc=0, icount unchanged.
  - HLT_STICKY=0: resume pulse → phase 5 next clk, icount+1 after phase 7.
- icount wrap with CNT_W=4: 16 instructions → icount 15→0. With CTRL_SINGLE_STEP_EN: no step → phase stays 0 indefinitely; single step pulse → exactly 8 phases then hold at 0.
